dff_output_monitor: RTL and testbench
=====================================

DFF_OUTPUT_MONITOR -- requirements
Module: dff_output_monitor

Interface
REQ-001 The parameter CNT_W SHALL have default 8 and SHALL set the width of each event counter.
REQ-002 The parameter ERR_W SHALL have default 4 and SHALL set the width of the error counter.
REQ-003 clk  input  1  clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 q_in  input  1  q output of the upstream flip-flop stage.
REQ-006 q_bar_in  input  1  q_bar output of the upstream flip-flop stage.
REQ-007 dff_reset  input  1  force/reset line driving the upstream stage; high means its outputs are forced to q=0, q_bar=1.
REQ-008 clear  input  1  synchronous clear of counters and sticky flag.
REQ-009 state  output  2  monitor state: INIT=2'd0, TRACK=2'd1, FORCED=2'd2.
REQ-010 rise_pulse  output  1  one-cycle pulse on a counted q rising edge.
REQ-011 fall_pulse  output  1  one-cycle pulse on a counted q falling edge.
REQ-012 rise_count  output  CNT_W  saturating count of rising edges.
REQ-013 fall_count  output  CNT_W  saturating count of falling edges.
REQ-014 err_pulse  output  1  one-cycle pulse on any detected error.
REQ-015 err_count  output  ERR_W  saturating count of errors.
REQ-016 err_sticky  output  1  set on first error; held until clear or reset.

Function
REQ-017 All outputs SHALL be registered; q_prev SHALL register q_in every cycle in every state.
REQ-018 INIT: no edges counted; next state FORCED if dff_reset=1, else TRACK.
REQ-019 TRACK: q_in=1 and q_prev=0 SHALL assert rise_pulse and increment rise_count after that edge; q_in=0 and q_prev=1 SHALL do likewise for fall_pulse and fall_count.
REQ-020 TRACK: dff_reset=1 SHALL move to FORCED on the same edge, and no edge SHALL be counted on that edge.
REQ-021 FORCED: no edges counted; the first cycle in FORCED is a grace cycle with no force check.
REQ-022 FORCED after the grace cycle: q_in!=0 or q_bar_in!=1 SHALL be a force error.
REQ-023 FORCED: dff_reset=0 SHALL move to INIT, so that the release transition is never counted as an edge.
REQ-024 In INIT or TRACK, q_in==q_bar_in SHALL be a complement error.
REQ-025 Any error SHALL assert err_pulse for one cycle, set err_sticky, and increment err_count by exactly 1, even when force and complement errors coincide.
REQ-026 All counters SHALL saturate at all-ones; no wrap-around.
REQ-027 Pulse outputs SHALL deassert in the cycle after assertion unless a new event occurs.
REQ-028 clear=1 SHALL zero rise_count, fall_count, err_count and err_sticky on that edge, overriding any simultaneous increment.
REQ-029 On a clear edge, pulses SHALL still reflect events on that edge, and state SHALL still transition normally.

Reset
REQ-030 reset=1 SHALL force state=INIT, q_prev=0, all counters=0, and all pulses and err_sticky=0 on that edge, overriding clear and all events.
REQ-031 Reset asserted mid-FORCED or mid-TRACK SHALL discard in-flight events; the first cycle after release is INIT.

Verification
REQ-032 Reset, then in TRACK toggle q_in/q_bar_in 0->1->0->1 one step per cycle -> rise_count=2, fall_count=1, each pulse one cycle wide, err_count=0.
REQ-033 In TRACK, drive q_in=1, q_bar_in=1 for 3 cycles -> err_count=3, err_sticky=1; then clear -> err_count=0, err_sticky=0.
REQ-034 Raise dff_reset with q_in=1; drop q_in to 0 and q_bar_in to 1 within the grace cycle; hold 4 cycles; release -> state sequence TRACK,FORCED..,INIT,TRACK, no errors, no fall counted.
REQ-035 In FORCED past the grace cycle, hold q_in=1 for 2 cycles -> err_count=2 with a single increment per cycle.
REQ-036 With CNT_W=8, generate 300 rising edges -> rise_count=255, holding at 255.
REQ-037 Assert reset and clear together with a rising edge in TRACK -> all counters 0, rise_pulse=0, state=INIT.

Source files
------------

// File: rtl/dff_output_monitor_if.sv
// dff_output_monitor_if: bus between a flip-flop stage monitor and its environment
// master drives the observed q/q_bar, the stage force line and clear;
// slave (the monitor) returns state, edge/error pulses, counters and sticky flag
interface dff_output_monitor_if #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
);
  logic             q_in;
  logic             q_bar_in;
  logic             dff_reset;
  logic             clear;
  logic [1:0]       state;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] rise_count;
  logic [CNT_W-1:0] fall_count;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             err_sticky;
  modport master (
    output q_in, q_bar_in, dff_reset, clear,
    input  state, rise_pulse, fall_pulse, rise_count, fall_count, err_pulse, err_count, err_sticky
  );
  modport slave (
    input  q_in, q_bar_in, dff_reset, clear,
    output state, rise_pulse, fall_pulse, rise_count, fall_count, err_pulse, err_count, err_sticky
  );
endinterface

// File: rtl/dff_output_monitor.sv
// dff_output_monitor: counts q edges of an upstream flip-flop and flags complement/force errors
// ports: clk, reset (sync, active-high), bus (slave modport: q_in, q_bar_in, dff_reset, clear in;
// state, rise/fall/err pulses, rise/fall/err counts, err_sticky out)
module dff_output_monitor #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input logic                 clk,
  input logic                 reset,
  dff_output_monitor_if.slave bus
);
  localparam logic [1:0] INIT = 2'd0, TRACK = 2'd1, FORCED = 2'd2;
  logic [1:0]       r_state;
  logic             r_q_prev, r_grace, r_rise_pulse, r_fall_pulse, r_err_pulse, r_err_sticky;
  logic [CNT_W-1:0] r_rise_count, r_fall_count;
  logic [ERR_W-1:0] r_err_count;
  logic             w_track, w_rise, w_fall, w_err;
  logic [1:0]       w_next;
  always_comb begin
    // leaving TRACK for FORCED suppresses edge counting on that same edge
    w_track = r_state == TRACK && !bus.dff_reset;
    w_rise  = w_track && bus.q_in && !r_q_prev;
    w_fall  = w_track && !bus.q_in && r_q_prev;
    // complement check outside FORCED, force check in FORCED past the grace cycle;
    // both fold into one error so a cycle never counts twice
    w_err   = (r_state != FORCED && bus.q_in == bus.q_bar_in) ||
              (r_state == FORCED && !r_grace && (bus.q_in || !bus.q_bar_in));
    // releasing FORCED goes through INIT so the release transition is never an edge
    w_next  = bus.dff_reset ? FORCED : r_state[1] ? INIT : TRACK;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= INIT;
      r_q_prev     <= 1'b0;
      r_grace      <= 1'b0;
      r_rise_pulse <= 1'b0;
      r_fall_pulse <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_rise_count <= '0;
      r_fall_count <= '0;
      r_err_count  <= '0;
    end else begin
      r_state      <= w_next;
      r_q_prev     <= bus.q_in;
      r_grace      <= bus.dff_reset && r_state != FORCED;
      r_rise_pulse <= w_rise;
      r_fall_pulse <= w_fall;
      r_err_pulse  <= w_err;
      r_err_sticky <= !bus.clear && (r_err_sticky || w_err);
      r_rise_count <= bus.clear ? '0 : (w_rise && !(&r_rise_count)) ? r_rise_count + CNT_W'(1) : r_rise_count;
      r_fall_count <= bus.clear ? '0 : (w_fall && !(&r_fall_count)) ? r_fall_count + CNT_W'(1) : r_fall_count;
      r_err_count  <= bus.clear ? '0 : (w_err && !(&r_err_count)) ? r_err_count + ERR_W'(1) : r_err_count;
    end
  end
  assign bus.state      = r_state;
  assign bus.rise_pulse = r_rise_pulse;
  assign bus.fall_pulse = r_fall_pulse;
  assign bus.rise_count = r_rise_count;
  assign bus.fall_count = r_fall_count;
  assign bus.err_pulse  = r_err_pulse;
  assign bus.err_count  = r_err_count;
  assign bus.err_sticky = r_err_sticky;
endmodule

// File: tb/tb_dff_output_monitor.sv
// tb_dff_output_monitor: table-driven directed check of dff_output_monitor
module tb_dff_output_monitor;
  typedef struct packed {
    logic       rst, clr, dres, q, qb;
    logic [1:0] st;
    logic       rp, fp;
    logic [7:0] rc, fc;
    logic       ep;
    logic [3:0] ec;
    logic       sk;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs [36];
  dff_output_monitor_if #(.CNT_W(8), .ERR_W(4)) bus ();
  dff_output_monitor #(.CNT_W(8), .ERR_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic rst, clr, dres, q, qb, input logic [1:0] st,
                              input logic rp, fp, input int rc, fc, input logic ep,
                              input int ec, input logic sk);
    mk = '{rst, clr, dres, q, qb, st, rp, fp, 8'(rc), 8'(fc), ep, 4'(ec), sk};
  endfunction
  function automatic logic [25:0] outs();
    outs = {bus.state, bus.rise_pulse, bus.fall_pulse, bus.rise_count, bus.fall_count,
            bus.err_pulse, bus.err_count, bus.err_sticky};
  endfunction
  task automatic drive(input logic rst, clr, dres, q, qb);
    reset = rst; bus.clear = clr; bus.dff_reset = dres; bus.q_in = q; bus.q_bar_in = qb;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    vecs[0]  = mk(1,0,0,0,1, 0,0,0,0,0,0,0,0);
    vecs[1]  = mk(0,0,0,0,1, 1,0,0,0,0,0,0,0);
    vecs[2]  = mk(0,0,0,1,0, 1,1,0,1,0,0,0,0);
    vecs[3]  = mk(0,0,0,0,1, 1,0,1,1,1,0,0,0);
    vecs[4]  = mk(0,0,0,1,0, 1,1,0,2,1,0,0,0);
    vecs[5]  = mk(0,0,0,1,0, 1,0,0,2,1,0,0,0);
    vecs[6]  = mk(0,0,0,1,1, 1,0,0,2,1,1,1,1);
    vecs[7]  = mk(0,0,0,1,1, 1,0,0,2,1,1,2,1);
    vecs[8]  = mk(0,0,0,1,1, 1,0,0,2,1,1,3,1);
    vecs[9]  = mk(0,1,0,1,0, 1,0,0,0,0,0,0,0);
    vecs[10] = mk(0,1,0,1,1, 1,0,0,0,0,1,0,0);
    vecs[11] = mk(0,0,0,1,0, 1,0,0,0,0,0,0,0);
    vecs[12] = mk(0,0,1,1,0, 2,0,0,0,0,0,0,0);
    vecs[13] = mk(0,0,1,0,1, 2,0,0,0,0,0,0,0);
    vecs[14] = mk(0,0,1,0,1, 2,0,0,0,0,0,0,0);
    vecs[15] = mk(0,0,1,0,1, 2,0,0,0,0,0,0,0);
    vecs[16] = mk(0,0,1,0,1, 2,0,0,0,0,0,0,0);
    vecs[17] = mk(0,0,0,0,1, 0,0,0,0,0,0,0,0);
    vecs[18] = mk(0,0,0,0,1, 1,0,0,0,0,0,0,0);
    vecs[19] = mk(0,0,0,1,0, 1,1,0,1,0,0,0,0);
    vecs[20] = mk(0,0,1,1,0, 2,0,0,1,0,0,0,0);
    vecs[21] = mk(0,0,1,1,0, 2,0,0,1,0,0,0,0);
    vecs[22] = mk(0,0,1,1,0, 2,0,0,1,0,1,1,1);
    vecs[23] = mk(0,0,1,1,0, 2,0,0,1,0,1,2,1);
    vecs[24] = mk(0,0,1,0,1, 2,0,0,1,0,0,2,1);
    vecs[25] = mk(0,0,0,0,1, 0,0,0,1,0,0,2,1);
    vecs[26] = mk(0,0,0,0,1, 1,0,0,1,0,0,2,1);
    vecs[27] = mk(1,1,0,1,0, 0,0,0,0,0,0,0,0);
    vecs[28] = mk(0,0,0,1,0, 1,0,0,0,0,0,0,0);
    vecs[29] = mk(0,0,0,1,0, 1,0,0,0,0,0,0,0);
    vecs[30] = mk(0,0,1,1,0, 2,0,0,0,0,0,0,0);
    vecs[31] = mk(1,0,1,0,1, 0,0,0,0,0,0,0,0);
    vecs[32] = mk(0,0,1,0,1, 2,0,0,0,0,0,0,0);
    vecs[33] = mk(0,0,1,1,0, 2,0,0,0,0,0,0,0);
    vecs[34] = mk(0,0,0,0,1, 0,0,0,0,0,0,0,0);
    vecs[35] = mk(0,0,0,0,1, 1,0,0,0,0,0,0,0);
    for (int i = 0; i < 36; i++) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].dres, vecs[i].q, vecs[i].qb);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i][25:0]));
    end
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 1);
    end
    check("rise_sat", 32'(bus.rise_count), 32'd255);
    check("fall_sat", 32'(bus.fall_count), 32'd255);
    drive(0, 0, 0, 1, 0);
    check("rise_hold", 32'({bus.rise_pulse, bus.rise_count}), 32'h1ff);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 1, 1);
    check("err_sat", 32'({bus.err_pulse, bus.err_count, bus.err_sticky}), 32'h3f);
    drive(1, 0, 0, 0, 1);
    check("final_reset", 32'(outs()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
